// File: rtl/ecc_pkg.sv
// Purpose: shared SECDED(39,32) codeword layout used by the encoder, the decoder and scrub logic.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package ecc_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ECC_WIDTH    = 7;
    localparam int SYN_WIDTH    = 6;
    localparam int CODEWORD_LEN = 38;

    // Codeword position (1..38) of data bit idx (0-based, d(idx+1)).
    // Positions that are powers of two are reserved for check bits.
    function automatic logic [SYN_WIDTH-1:0] data_pos(input int idx);
        logic [SYN_WIDTH-1:0] res;
        int                   cnt;
        res = '0;
        cnt = 0;
        for (int p = 1; p <= CODEWORD_LEN; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) begin
                    res = SYN_WIDTH'(p);
                end
                cnt++;
            end
        end
        return res;
    endfunction

    // Data bits covered by Hamming check bit k (k = 1..6): those whose
    // position has bit (k-1) set.
    function automatic logic [DATA_WIDTH-1:0] hamming_mask(input int k);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = ((int'(data_pos(i)) >> (k - 1)) & 1) != 0;
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Purpose: combinational SECDED syndrome and overall parity of a received (data, ecc) pair.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller owns any handshake.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ECC_WIDTH-1:0]  ecc,
    output logic [SYN_WIDTH:1]    s,
    output logic                  p
);

    // Each syndrome bit re-checks one Hamming group against its stored check bit.
    always_comb begin
        s = '0;
        for (int k = 1; k <= SYN_WIDTH; k++) begin
            s[k] = ecc[k] ^ (^(data & hamming_mask(k)));
        end
    end

    // Overall parity spans every received bit, including ecc[0].
    assign p = (^data) ^ (^ecc);

endmodule

// File: rtl/ecc_decode_stage.sv
// Purpose: SECDED check/correct on the FIFO read path with error counters and syndrome capture.
// Latency: 2 cycles from input transfer to out_valid when not stalled; 1 word/cycle throughput.
// Backpressure: out_ready low stalls S2, then S1, then drops in_ready; nothing lost or reordered.
module ecc_decode_stage
    import ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ECC_WIDTH-1:0]  in_ecc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sbe,
    output logic                  out_dbe,
    output logic [CNT_WIDTH-1:0]  sbe_count,
    output logic [CNT_WIDTH-1:0]  dbe_count,
    output logic [ECC_WIDTH-1:0]  last_syndrome,
    input  logic                  clr_counts
);

    logic [SYN_WIDTH:1]    syn_s;
    logic                  syn_p;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [SYN_WIDTH:1]    s1_s;
    logic                  s1_p;

    logic [ECC_WIDTH-1:0]  s2_syn;

    logic                  s1_adv;
    logic                  s2_adv;
    logic                  out_fire;

    logic [DATA_WIDTH-1:0] fix_data;
    logic                  fix_sbe;
    logic                  fix_dbe;

    ecc_syndrome u_syndrome (
        .data (in_data),
        .ecc  (in_ecc),
        .s    (syn_s),
        .p    (syn_p)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = out_valid && out_ready;

    // S1: capture the raw word with its syndrome and overall parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_s     <= '0;
            s1_p     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_s    <= syn_s;
                s1_p    <= syn_p;
            end
        end
    end

    // Classify the S1 syndrome and flip the addressed data bit on a correctable error.
    always_comb begin
        fix_data = s1_data;
        fix_sbe  = 1'b0;
        fix_dbe  = 1'b0;
        if (s1_p) begin
            if (s1_s > SYN_WIDTH'(CODEWORD_LEN)) begin
                fix_dbe = 1'b1;
            end else begin
                fix_sbe = 1'b1;
                // s == 0 or a power of two points at a check bit: data is already right.
                if ((s1_s & (s1_s - 6'd1)) != 6'd0) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (data_pos(i) == s1_s) begin
                            fix_data[i] = ~s1_data[i];
                        end
                    end
                end
            end
        end else if (s1_s != '0) begin
            fix_dbe = 1'b1;
        end
    end

    // S2: output register, held while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sbe   <= 1'b0;
            out_dbe   <= 1'b0;
            s2_syn    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= fix_data;
                out_sbe  <= fix_sbe;
                out_dbe  <= fix_dbe;
                s2_syn   <= {s1_p, s1_s};
            end
        end
    end

    // Status: saturating counters and last error syndrome, updated on output transfer; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_count     <= '0;
            dbe_count     <= '0;
            last_syndrome <= '0;
        end else if (clr_counts) begin
            sbe_count     <= '0;
            dbe_count     <= '0;
            last_syndrome <= '0;
        end else if (out_fire) begin
            if (out_sbe && (sbe_count != '1)) begin
                sbe_count <= sbe_count + 1'b1;
            end
            if (out_dbe && (dbe_count != '1)) begin
                dbe_count <= dbe_count + 1'b1;
            end
            if (out_sbe || out_dbe) begin
                last_syndrome <= s2_syn;
            end
        end
    end

endmodule

// File: tb/tb_ecc_decode_stage.sv
// Purpose: randomized scoreboard bench for ecc_decode_stage against a codeword-level model.
// Latency: checks the 2-cycle unstalled latency on a directed word.
// Backpressure: random and forced out_ready stalls; hold-stability checked every stalled cycle.
module tb_ecc_decode_stage;

    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] data;
        logic        sbe;
        logic        dbe;
        logic [6:0]  syn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic [6:0]    in_ecc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic          out_sbe;
    logic          out_dbe;
    logic [CW-1:0] sbe_count;
    logic [CW-1:0] dbe_count;
    logic [6:0]    last_syndrome;
    logic          clr_counts = 1'b0;

    logic          force_stall = 1'b0;
    logic          rand_ready = 1'b0;

    int   total = 0;
    int   passed = 0;
    exp_t q[$];

    int          m_sbe = 0;
    int          m_dbe = 0;
    logic [6:0]  m_last = '0;
    logic        held = 1'b0;
    logic [33:0] held_val = '0;

    ecc_decode_stage #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_ecc        (in_ecc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sbe       (out_sbe),
        .out_dbe       (out_dbe),
        .sbe_count     (sbe_count),
        .dbe_count     (dbe_count),
        .last_syndrome (last_syndrome),
        .clr_counts    (clr_counts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Lay the 39 received bits out by codeword position: index 0 is the overall parity bit.
    function automatic logic [38:0] to_cw(input logic [31:0] d, input logic [6:0] e);
        logic [38:0] cw;
        int di = 0;
        int k = 1;
        cw = '0;
        cw[0] = e[0];
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) == 0) begin cw[pos] = e[k]; k++; end
            else begin cw[pos] = d[di]; di++; end
        end
        return cw;
    endfunction

    function automatic void from_cw(input logic [38:0] cw, output logic [31:0] d, output logic [6:0] e);
        int di = 0;
        int k = 1;
        d = '0;
        e = '0;
        e[0] = cw[0];
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) == 0) begin e[k] = cw[pos]; k++; end
            else begin d[di] = cw[pos]; di++; end
        end
    endfunction

    // Classic Hamming view: the syndrome is the XOR of the positions of all set bits.
    function automatic int pos_xor(input logic [38:0] cw);
        int x = 0;
        for (int pos = 1; pos <= 38; pos++) if (cw[pos]) x ^= pos;
        return x;
    endfunction

    function automatic logic [6:0] encode(input logic [31:0] d);
        logic [6:0] e;
        int x;
        x = pos_xor(to_cw(d, 7'h00));
        e = {x[5:0], 1'b0};
        e[0] = (^d) ^ (^e[6:1]);
        return e;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] d, input logic [6:0] e);
        logic [38:0] cw;
        logic [6:0]  e2;
        exp_t r;
        int x;
        logic p;
        cw = to_cw(d, e);
        x = pos_xor(cw);
        p = ^cw;
        r.syn = {p, x[5:0]};
        r.sbe = 1'b0;
        r.dbe = 1'b0;
        if (!p && x != 0) r.dbe = 1'b1;
        else if (p && x > 38) r.dbe = 1'b1;
        else if (p) begin
            r.sbe = 1'b1;
            cw[x] = ~cw[x];
        end
        from_cw(cw, r.data, e2);
        return r;
    endfunction

    // Ready generator: drives out_ready after the driver's own input updates.
    always begin
        @(posedge clk);
        #2;
        out_ready = force_stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: scoreboard pop/compare, hold stability, status model, and input capture.
    always @(negedge clk) begin
        exp_t ex;
        if (!rst_n) begin
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_counts", {sbe_count, dbe_count, last_syndrome}, '0);
            q.delete();
            m_sbe = 0;
            m_dbe = 0;
            m_last = '0;
            held = 1'b0;
        end else begin
            check("status", {16'(sbe_count), 16'(dbe_count), 8'(last_syndrome)},
                  {16'(m_sbe), 16'(m_dbe), 8'(m_last)});
            if (held) begin
                check("hold", {out_valid, out_data, out_sbe, out_dbe}, {1'b1, held_val});
            end
            held = out_valid && !out_ready;
            held_val = {out_data, out_sbe, out_dbe};
            ex = '0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    ex = q.pop_front();
                    check("out_word", {out_data, out_sbe, out_dbe}, {ex.data, ex.sbe, ex.dbe});
                end
            end
            if (clr_counts) begin
                m_sbe = 0;
                m_dbe = 0;
                m_last = '0;
            end else if (out_valid && out_ready) begin
                if (ex.sbe && m_sbe < MAX) m_sbe++;
                if (ex.dbe && m_dbe < MAX) m_dbe++;
                if (ex.sbe || ex.dbe) m_last = ex.syn;
            end
            if (in_valid && in_ready) q.push_back(ref_decode(in_data, in_ecc));
        end
    end

    task automatic send(input logic [31:0] d, input logic [6:0] e);
        int n = 0;
        logic ok;
        in_data = d;
        in_ecc = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
    endtask

    task automatic send_random();
        logic [31:0] d;
        logic [6:0]  e;
        logic [38:0] cw;
        int kind, j1, j2;
        d = $urandom();
        e = encode(d);
        kind = $urandom_range(0, 3);
        cw = to_cw(d, e);
        j1 = $urandom_range(0, 38);
        j2 = (j1 + $urandom_range(1, 38)) % 39;
        if (kind >= 1) cw[j1] = ~cw[j1];
        if (kind >= 2) cw[j2] = ~cw[j2];
        from_cw(cw, d, e);
        if (kind == 3) begin
            d = $urandom();
            e = 7'($urandom());
        end
        send(d, e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        check("out_after_reset", {out_valid, out_data, out_sbe, out_dbe}, '0);
        @(posedge clk);
        #1;

        // Valid codeword and 2-cycle latency.
        send(32'h0000_0001, 7'h07);
        in_valid = 1'b0;
        check("latency_c1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_c2", {out_valid, out_data, out_sbe, out_dbe}, {1'b1, 32'h1, 2'b00});
        drain();

        // d1 flipped, corrected.
        send(32'h0000_0000, 7'h07);
        in_valid = 1'b0;
        drain();
        check("sbe_d1", {32'(sbe_count), 32'(last_syndrome)}, {32'd1, 32'h43});

        // Overall parity bit error.
        send(32'h0000_0000, 7'h01);
        in_valid = 1'b0;
        drain();
        check("sbe_p0", {32'(sbe_count), 32'(last_syndrome)}, {32'd2, 32'h40});

        // Double error.
        send(32'h0000_0003, 7'h00);
        in_valid = 1'b0;
        drain();
        check("dbe", {32'(dbe_count), 32'(last_syndrome)}, {32'd1, 32'h06});

        // Saturation.
        for (int i = 0; i < 5; i++) send(32'h0000_0000, 7'h07);
        in_valid = 1'b0;
        drain();
        check("sbe_saturate", 64'(sbe_count), 64'd3);

        // Clear collides with an sbe transfer.
        clr_counts = 1'b1;
        send(32'h0000_0000, 7'h07);
        in_valid = 1'b0;
        drain();
        clr_counts = 1'b0;
        check("clear_wins", {sbe_count, dbe_count, last_syndrome}, '0);

        // Forced 5-cycle stall with 4 back-to-back words.
        force_stall = 1'b1;
        @(posedge clk);
        #3;
        fork
            begin
                for (int i = 0; i < 4; i++) send_random();
                in_valid = 1'b0;
            end
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        force_stall = 1'b0;
        wait fork;
        drain();

        // Randomized traffic with backpressure, gaps, clears and a mid-stream reset.
        rand_ready = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("ready_after_midreset", 64'(in_ready), 64'd1);
                @(posedge clk);
                #1;
            end
            clr_counts = ($urandom_range(0, 40) == 0);
            send_random();
            clr_counts = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ecc_decode_stage.md
# ecc_decode_stage

Pipelined SECDED check/correct stage on the FIFO read path. It takes each 32-bit data word together with the 7 check bits produced by the encoder at write time and recomputes the syndrome. It corrects any single-bit error, flags double-bit errors, and presents the corrected word downstream under a valid/ready handshake. It also keeps saturating error counters and a sticky capture of the last error syndrome for status readout.

## Interface
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ECC_WIDTH, 7, check-bit width; only 7 is supported.
- CNT_WIDTH, 16, width of each error counter.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream word available.
- in_ready  out  1  stage accepts word this cycle.
- in_data  in  DATA_WIDTH  stored data, bit i = data bit d(i+1).
- in_ecc  in  ECC_WIDTH  stored check bits: [0] overall parity, [k] Hamming parity for position 2^(k-1), k=1..6.
- out_valid  out  1  corrected word available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  corrected data.
- out_sbe  out  1  single-bit error corrected for this word.
- out_dbe  out  1  uncorrectable error for this word; data passed through unmodified.
- sbe_count, dbe_count  out  CNT_WIDTH  saturating error counters.
- last_syndrome  out  7  {overall parity, s[6:1]} of the most recent erroneous word.
- clr_counts  in  1  synchronous clear of both counters and last_syndrome.

## Operation
- Codeword layout (positions 1..38):
  - check bits sit at positions 1, 2, 4, 8, 16 and 32;
  - data bits d1..d32 fill the remaining positions in ascending order (d1 at 3, d4 at 7, d5 at 9, d12 at 17, d27 at 33, d32 at 38).
- s[k] = in_ecc[k] XOR parity of data bits whose position has bit (k-1) set.
- p = XOR of all 39 received bits.
- Classification:
  - s=0, p=0: clean.
  - p=1, s=0: error in in_ecc[0]; sbe, data unchanged.
  - p=1, s a power of two: check-bit error; sbe, data unchanged.
  - p=1, s a data position (3..38, not a power of two): flip that data bit; sbe.
  - p=1, s>38: dbe.
  - p=0, s≠0: dbe.
- Counters:
  - sbe_count / dbe_count increment on the output transfer (out_valid & out_ready) of a word with the matching flag.
  - Both saturate at all-ones.
- last_syndrome loads {p, s} on each output transfer with sbe or dbe.
- clr_counts in the same cycle as an increment: clear wins, result 0.

## Timing
- Two register stages:
  - S1 registers data, s and p.
  - S2 registers corrected data and flags.
- Latency from in transfer to out_valid is 2 cycles when not stalled.
- Throughput is 1 word/cycle.
- Handshake:
  - Stall rule: S2 advances if !s2_valid | out_ready. S1 advances if !s1_valid | S2 advances. in_ready = S1 advances.
  - in_ready does not depend combinationally on in_valid.
  - out_data, out_sbe and out_dbe hold stable while out_valid & !out_ready.
  - Once asserted, out_valid stays high until the transfer completes.
- Reset values:
  - s1_valid, out_valid = 0; out_data = 0; out_sbe, out_dbe = 0.
  - Counters = 0; last_syndrome = 0.
  - in_ready = 1 in the first cycle after reset deassertion.
- Reset mid-operation drops all in-flight words; no partial output.
- The pipeline holds at most 2 words; no word is lost or reordered under any out_ready pattern.

## Structure
- Shared package ecc_pkg holds:
  - DATA_WIDTH and ECC_WIDTH constants;
  - the data-bit-to-position map as a constant function;
  - CODEWORD_LEN = 38.
- The encoder and this stage both use ecc_pkg, so the layout is defined once.
- Sub-module ecc_syndrome is purely combinational. Inputs: data and ecc. Outputs: s[6:1] and p. It is reusable by scrub logic.
- Correction decode and the counters stay in the top module.

## Test plan
- in_data=0x00000001, in_ecc=0x07 (valid codeword), out_ready=1 -> out_data=0x00000001 two cycles later, sbe=0, dbe=0.
- in_data=0x00000000, in_ecc=0x07 (d1 flipped) -> s=3, p=1; out_data=0x00000001, out_sbe=1, sbe_count=1, last_syndrome=0x43.
- in_data=0x00000000, in_ecc=0x01 -> out_data=0, out_sbe=1 (overall-parity bit error).
- in_data=0x00000003, in_ecc=0x00 -> s=6, p=0; out_dbe=1, out_data=0x00000003, dbe_count=1.
- 4 back-to-back words with out_ready=0 for 5 cycles -> in_ready low after 2 accepted; after release, all 4 words emerge in order, each held stable while stalled.
- CNT_WIDTH=2 with 5 sbe words -> sbe_count=3. Then clr_counts together with a 6th sbe word -> count 0. Then rst_n pulse mid-stream -> out_valid=0 and counters=0 immediately.
